// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 4-digit seven-segment scan controller with blanking, PWM and frame-buffered value
// Optional feature macro: LZ_BLANK_EN (leading-zero suppression).
module seg7_scan_ctrl #(
    parameter int DIGIT_CYCLES = 3000,
    parameter int BLANK_CYCLES = 48,
    parameter int CNT_W        = 12
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] VALUE,
    input  logic        LOAD,
    input  logic [3:0]  DIG_EN,
    input  logic [3:0]  BRIGHT,
    output logic [6:0]  SEG,
    output logic [3:0]  COMM,
    output logic        FRAME,
    output logic        PENDING
);
    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       dig;
    logic [3:0]       pwm;
    logic [15:0]      active;
    logic [15:0]      staging;

    logic             slot_end;
    logic             frame_end;
    logic             lit;
    logic [3:0]       nibble;
    logic [3:0]       eligible;
    logic [6:0]       glyph;

    assign slot_end  = (cnt == SLOT_LAST);
    assign frame_end = slot_end && (dig == 2'd3);
    assign nibble    = active[{dig, 2'b00} +: 4];

`ifdef LZ_BLANK_EN
    // A digit is eligible once any nibble at or above it is non-zero; digit 0 always shows.
    assign eligible = {|active[15:12], |active[15:8], |active[15:4], 1'b1};
`else
    assign eligible = 4'b1111;
`endif

    assign lit = (state == ST_DRIVE) && DIG_EN[dig] && eligible[dig]
                 && ({1'b0, pwm} < ({1'b0, BRIGHT} + 5'd1));

    always_comb begin
        glyph = 7'b0000000;
        case (nibble)
            4'h0: glyph = 7'b0111111;
            4'h1: glyph = 7'b0000110;
            4'h2: glyph = 7'b1011011;
            4'h3: glyph = 7'b1001111;
            4'h4: glyph = 7'b1100110;
            4'h5: glyph = 7'b1101101;
            4'h6: glyph = 7'b1111101;
            4'h7: glyph = 7'b0000111;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1101111;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b1111100;
            4'hC: glyph = 7'b0111001;
            4'hD: glyph = 7'b1011110;
            4'hE: glyph = 7'b1111001;
            4'hF: glyph = 7'b1110001;
            default: glyph = 7'b0000000;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= ST_BLANK;
            cnt     <= '0;
            dig     <= 2'd0;
            pwm     <= 4'd0;
            active  <= 16'h0000;
            staging <= 16'h0000;
            SEG     <= 7'b0000000;
            COMM    <= 4'b1111;
            FRAME   <= 1'b0;
            PENDING <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt   <= '0;
                dig   <= dig + 2'd1;
                state <= ST_BLANK;
            end else begin
                cnt <= cnt + 1'b1;
                if (state == ST_BLANK && cnt == BLANK_LAST) begin
                    state <= ST_DRIVE;
                end
            end

            pwm <= (state == ST_DRIVE && !slot_end) ? pwm + 4'd1 : 4'd0;

            SEG   <= lit ? glyph : 7'b0000000;
            COMM  <= lit ? ~(4'b0001 << dig) : 4'b1111;
            FRAME <= frame_end;

            // Active only changes at the frame boundary so a frame never mixes two values.
            if (frame_end) begin
                if (LOAD) begin
                    active  <= VALUE;
                    staging <= VALUE;
                    PENDING <= 1'b0;
                end else if (PENDING) begin
                    active  <= staging;
                    PENDING <= 1'b0;
                end
            end else if (LOAD) begin
                staging <= VALUE;
                PENDING <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;
    localparam int D = 10;
    localparam int B = 2;
    localparam int F = 4 * D;
`ifdef LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] VALUE = 16'h0000;
    logic        LOAD = 1'b0;
    logic [3:0]  DIG_EN = 4'hF;
    logic [3:0]  BRIGHT = 4'hF;
    logic [6:0]  SEG;
    logic [3:0]  COMM;
    logic        FRAME;
    logic        PENDING;

    int tests = 0;
    int fails = 0;

    seg7_scan_ctrl #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B), .CNT_W(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .VALUE(VALUE), .LOAD(LOAD), .DIG_EN(DIG_EN),
        .BRIGHT(BRIGHT), .SEG(SEG), .COMM(COMM), .FRAME(FRAME), .PENDING(PENDING)
    );

    always #5 CLK = ~CLK;

    logic [6:0] font [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                              7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                              7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                              7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    task automatic check(string name, int unsigned act, int unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position j counts edges since reset; slot, digit and pwm follow by arithmetic.
    int          j = 0;
    logic [15:0] m_act = 16'h0000;
    logic [15:0] m_stg = 16'h0000;
    logic        m_pend = 1'b0;
    logic [3:0]  e_comm = 4'hF;
    logic [6:0]  e_seg = 7'h00;
    logic        e_frame = 1'b0;

    always @(posedge CLK) begin
        int c, d, p, nib;
        bit on, bnd, elig;
        if (!RST_N) begin
            j = 0; m_act = 0; m_stg = 0; m_pend = 0;
            e_comm = 4'hF; e_seg = 0; e_frame = 0;
        end else begin
            c    = j % D;
            d    = (j / D) % 4;
            p    = (c - B) % 16;
            nib  = int'((m_act >> (4 * d)) & 16'hF);
            elig = !LZ || d == 0 || (m_act >> (4 * d)) != 0;
            on   = (c >= B) && DIG_EN[d] && elig && (p < int'(BRIGHT) + 1);
            e_comm  = on ? ~(4'b0001 << d) : 4'hF;
            e_seg   = on ? font[nib] : 7'h00;
            bnd     = (c == D - 1) && (d == 3);
            e_frame = bnd;
            if (bnd) begin
                if (LOAD) begin m_act = VALUE; m_stg = VALUE; m_pend = 0; end
                else if (m_pend) begin m_act = m_stg; m_pend = 0; end
            end else if (LOAD) begin
                m_stg = VALUE; m_pend = 1;
            end
            j++;
        end
    end

    always @(negedge CLK) begin
        check("comm", COMM, e_comm);
        check("seg", SEG, e_seg);
        check("frame", FRAME, e_frame);
        check("pending", PENDING, m_pend);
        check("onehot0", $onehot0(~COMM), 1);
    end

    int lowcnt [4];
    int first [4];
    logic [6:0] segv [4];
    int blanks;
    bit pend_seen;

    task automatic capture();
        for (int i = 0; i < 4; i++) begin lowcnt[i] = 0; first[i] = -1; segv[i] = 0; end
        blanks = 0; pend_seen = 0;
        for (int m = 0; m < F; m++) begin
            @(negedge CLK);
            if (PENDING) pend_seen = 1;
            if (COMM == 4'hF) blanks++;
            for (int i = 0; i < 4; i++) begin
                if (!COMM[i]) begin
                    lowcnt[i]++;
                    segv[i] = SEG;
                    if (first[i] < 0) first[i] = m;
                end
            end
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin @(negedge CLK); n++; end while (!FRAME && n < 100);
        check("frame_seen", FRAME, 1);
    endtask

    task automatic wait_pos(int pos);
        int n = 0;
        while (j % F != pos && n < 200) begin @(negedge CLK); n++; end
        tests++;
        if (n >= 200) begin fails++; $display("FAIL align: position %0d never reached", pos); end
    endtask

    task automatic first_low_latency(string name);
        int n = 0;
        do begin
            @(negedge CLK); n++;
            if (n == 1) begin check({name, "_pend"}, PENDING, LOAD); LOAD = 0; end
        end while (COMM == 4'hF && n < 50);
        check(name, n, B + 1);
        check({name, "_seg"}, SEG, 7'b0111111);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_comm", COMM, 4'hF);
        check("rst_seg", SEG, 0);
        check("rst_frame", FRAME, 0);
        check("rst_pend", PENDING, 0);

        // Release with a load of 0x1234; applied at the first frame boundary.
        VALUE = 16'h1234; LOAD = 1; RST_N = 1;
        first_low_latency("release_latency");
        wait_frame();
        check("f1_pend", PENDING, 0);
        capture();
        check("f1_blanks", blanks, 8);
        for (int i = 0; i < 4; i++) begin
            check("f1_lowcnt", lowcnt[i], 8);
            check("f1_first", first[i], 10 * i + 2);
        end
        check("f1_seg0", segv[0], 7'b1100110);
        check("f1_seg1", segv[1], 7'b1001111);
        check("f1_seg2", segv[2], 7'b1011011);
        check("f1_seg3", segv[3], 7'b0000110);

        // Last load of a frame wins.
        repeat (12) @(negedge CLK);
        VALUE = 16'hABCD; LOAD = 1; @(negedge CLK);
        LOAD = 0; @(negedge CLK);
        VALUE = 16'h8888; LOAD = 1; @(negedge CLK);
        LOAD = 0;
        check("ovw_pend", PENDING, 1);
        wait_frame();
        check("ovw_pend_clr", PENDING, 0);
        capture();
        for (int i = 0; i < 4; i++) check("ovw_seg", segv[i], 7'b1111111);

        // Load exactly on the boundary cycle bypasses staging.
        wait_pos(F - 1);
        VALUE = 16'h00F0; LOAD = 1; @(negedge CLK);
        LOAD = 0;
        check("bnd_frame", FRAME, 1);
        check("bnd_pend", PENDING, 0);
        capture();
        check("bnd_pend_seen", pend_seen, 0);
        check("bnd_seg1", segv[1], 7'b1110001);
        check("bnd_seg0", segv[0], 7'b0111111);
        check("bnd_low3", lowcnt[3], LZ ? 0 : 8);

        // Brightness and per-digit enable.
        BRIGHT = 4'd3; DIG_EN = 4'b0101;
        capture();
        check("pwm_low0", lowcnt[0], 4);
        check("pwm_first0", first[0], 2);
        check("pwm_low1", lowcnt[1], 0);
        check("pwm_low2", lowcnt[2], LZ ? 0 : 4);
        check("pwm_low3", lowcnt[3], 0);
        BRIGHT = 4'hF; DIG_EN = 4'hF;

        // Reset in the middle of digit 2 drive with a value staged.
        wait_pos(20);
        VALUE = 16'h5555; LOAD = 1; @(negedge CLK);
        LOAD = 0;
        wait_pos(25);
        RST_N = 0; @(negedge CLK);
        check("mid_rst_comm", COMM, 4'hF);
        check("mid_rst_seg", SEG, 0);
        check("mid_rst_pend", PENDING, 0);
        RST_N = 1;
        first_low_latency("restart_latency");

        // Leading zeros: value 0, then 0x0400.
        wait_frame();
        capture();
        check("zero_low0", lowcnt[0], 8);
        check("zero_seg0", segv[0], 7'b0111111);
        check("zero_low3", lowcnt[3], LZ ? 0 : 8);
        VALUE = 16'h0400; LOAD = 1; @(negedge CLK);
        LOAD = 0;
        wait_frame();
        capture();
        check("lz_low2", lowcnt[2], 8);
        check("lz_seg2", segv[2], 7'b1100110);
        check("lz_low1", lowcnt[1], 8);
        check("lz_low3", lowcnt[3], LZ ? 0 : 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit common-cathode seven-segment display on the UPduino breadboard. It takes a 16-bit hex value and drives one digit at a time: it enables one cathode on COMM, decodes that digit onto SEG, and inserts a blanking gap between digits to prevent ghosting. Value updates are double-buffered and applied only at frame boundaries, so the display never tears. PWM brightness control is included. It sits between top-level logic and the SEG/COMM pins.

Parameters:
DIGIT_CYCLES, 3000, clocks per digit slot including blank (12 MHz / 3000 = 4 kHz slot, 1 kHz frame); must be > BLANK_CYCLES
BLANK_CYCLES, 48, clocks at start of each slot with all cathodes off; must be >= 1
CNT_W, 12, width of slot counter; must hold DIGIT_CYCLES-1

Ports:
CLK  input  1  system clock (12 MHz)
RST_N  input  1  synchronous active-low reset
VALUE  input  16  hex value; nibble i shown on digit i (digit 0 = VALUE[3:0], COMM[0])
LOAD  input  1  single-cycle strobe; captures VALUE into staging register
DIG_EN  input  4  per-digit enable; 0 keeps that cathode off for its slot
BRIGHT  input  4  brightness, 0 = 1/16 duty, 15 = full
SEG  output  7  segments a..g on SEG[0]..SEG[6], active high
COMM  output  4  cathodes, active low, at most one low at any time
FRAME  output  1  one-cycle pulse on frame boundary (end of digit 3 slot)
PENDING  output  1  staged value not yet applied

Behaviour:
- One clock, CLK. Reset is synchronous and active-low on RST_N. All state changes occur on posedge CLK.
- Reset values: SEG=0, COMM=4'b1111, FRAME=0, PENDING=0, active=0, staging=0, digit index=0, slot counter=0, state=BLANK, pwm counter=0.
- FSM states:
  - BLANK: COMM=1111, SEG=0 for BLANK_CYCLES clocks, then go to DRIVE.
  - DRIVE: lasts DIGIT_CYCLES-BLANK_CYCLES clocks. At the end, the digit index advances (3 wraps to 0) and the FSM returns to BLANK.
- The slot counter counts 0..DIGIT_CYCLES-1 and resets at every slot end. The slot end is the cycle where counter = DIGIT_CYCLES-1.
- After reset, the first cathode goes low on the cycle after the counter reaches BLANK_CYCLES-1, i.e. at clock edge BLANK_CYCLES+1 counted from the release edge.
- DRIVE output gating:
  - COMM[i] and SEG are driven only when DIG_EN[i]=1 and pwm < BRIGHT+1 (5-bit compare, so BRIGHT=15 is always on).
  - Otherwise COMM=1111 and SEG=0.
  - pwm is a 4-bit counter that increments every DRIVE cycle and clears on entry to BLANK.
- Outputs are registered: SEG and COMM reflect the state/counter of the previous cycle, giving one cycle of latency.
- Hex decode (g..a): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- Buffering:
  - LOAD writes staging<=VALUE and sets PENDING.
  - A LOAD during a frame overwrites staging; the last LOAD wins.
  - Frame boundary is the slot-end cycle of digit 3. On that cycle: FRAME=1 (registered, visible next cycle); if PENDING, active<=staging and PENDING clears.
  - If LOAD coincides with the boundary cycle, active<=VALUE directly and PENDING stays 0.
- DIG_EN and BRIGHT are sampled live every cycle and are not buffered.
- Reset mid-frame: immediate return to the reset state; staged data is lost; COMM goes 1111 on the reset edge.
- COMM is never low for two digits simultaneously, including across slot transitions. This is guaranteed by BLANK.

Optional Feature:
Macro LZ_BLANK_EN enables leading-zero suppression.
- Defined: digit i (i = 3..1) is treated as DIG_EN[i]=0 when active nibbles i..3 are all zero. Digit 0 is always eligible. Example: active=0x0040 shows digits 1 and 0 only.
- Undefined: all enabled digits display, including leading zeros.

Test Plan:
- Params DIGIT_CYCLES=10, BLANK_CYCLES=2. Release reset with VALUE=0x1234 and LOAD on cycle 0 → active applied at the first FRAME. In the following frame:
  - COMM cycles 1110→1101→1011→0111, each low for 8 clocks, separated by 2 clocks of 1111.
  - SEG shows 0x4→1100110, 0x3→1001111, 0x2→1011011, 0x1→0000110.
- LOAD 0xABCD mid-frame, then LOAD 0x8888 two cycles later → PENDING=1; the next frame shows 8 on all digits; 0xABCD is never displayed; PENDING clears with the FRAME pulse.
- LOAD asserted exactly on the digit-3 slot-end cycle with VALUE=0x00F0 → the next frame shows F on digit 1; PENDING never goes high.
- BRIGHT=3, DIG_EN=4'b0101 → within each 8-cycle DRIVE window, COMM[0]/COMM[2] are low for the first 4 cycles then high. COMM[1] and COMM[3] are never low. `$onehot0(~COMM)` holds every cycle.
- RST_N low mid-DRIVE on digit 2 → next cycle COMM=1111, SEG=0, PENDING=0. Restart timing matches the post-reset case.
- With LZ_BLANK_EN defined and active=0x0000 → only COMM[0] ever goes low, showing 0111111. With active=0x0400 → digits 2, 1, 0 are shown and digit 3 is suppressed.
